// File: rtl/fir_pkg.sv
// Shared FIR definitions: accumulator/output widths, sample types, output-stage FSM states
// and the debug view of the output stage.
package fir_pkg;

    localparam int FIR_ACC_W = 64;
    localparam int FIR_OUT_W = 32;

    typedef logic signed [FIR_ACC_W-1:0] fir_acc_t;
    typedef logic signed [FIR_OUT_W-1:0] fir_out_t;

    typedef enum logic {
        Q_WARM,
        Q_RUN
    } quant_state_e;

    typedef struct packed {
        quant_state_e state;
        logic         fifo_full;
    } quant_dbg_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO with a registered head. Entries become visible at the head one edge after
// they are written. A push into a full FIFO is dropped unless the head is popped on the same edge.
module fir_out_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         head_vld_q, head_vld_d;
    logic [W-1:0] head_q, head_d;
    logic         pop;
    logic         accept;

    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = head_vld_q & rdy_i;
    assign accept = push_i & (~full_o | pop);
    assign drop_o = push_i & full_o & ~pop;
    assign vld_o  = head_vld_q;
    assign data_o = head_q;

    // The head is taken from entries already in memory; this edge's write shows up one edge later.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        wr_ptr_d   = wr_ptr_q + (AW+1)'(accept);
        head_vld_d = (wr_ptr_q != rd_ptr_d);
        head_d     = head_q;
        if (head_vld_d) begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output stage: discards warm-up samples, rounds/shifts/saturates the accumulator, buffers
// results in an output FIFO. Define FIR_OUT_QUANT_STATS_EN to build the saturation counter.
module fir_out_quant
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_ACC_W,
    parameter int OUT_W      = FIR_OUT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [IN_W-1:0]  y_in,
    input  logic [5:0]       shift,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [OUT_W-1:0] q_out,
    output logic             ovf,
    output logic [15:0]      sat_cnt,
    output quant_dbg_t       dbg
);
    localparam int SW  = IN_W + 1;
    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [5:0] SH_MAX = 6'(IN_W - 1);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam quant_state_e ST_RST = (WARMUP == 0) ? Q_RUN : Q_WARM;

    quant_state_e     state_q, state_d;
    logic [WCW-1:0]   warm_q, warm_d;
    logic             stage_en;
    logic [5:0]       sh;
    logic signed [SW-1:0] ext, rnd, sum, r;
    logic             sat_hi, sat_lo;
    logic [OUT_W-1:0] stg_data_d, stg_data_q;
    logic             stg_vld_q;
    logic             ovf_q;
    logic             fifo_full, fifo_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RST;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        stage_en = 1'b0;
        case (state_q)
            Q_WARM: begin
                if (in_vld) begin
                    warm_d = warm_q + WCW'(1);
                    if (warm_d == WCW'(WARMUP)) begin
                        state_d = Q_RUN;
                    end
                end
            end
            Q_RUN:   stage_en = in_vld;
            default: state_d = ST_RST;
        endcase
    end

    // One extra bit of headroom keeps the half-LSB rounding add from wrapping.
    always_comb begin
        sh  = (shift > SH_MAX) ? SH_MAX : shift;
        ext = {y_in[IN_W-1], y_in};
        rnd = '0;
        if (sh != 6'd0) begin
            rnd = SW'(1) << (sh - 6'd1);
        end
        sum    = ext + rnd;
        r      = sum >>> sh;
        sat_hi = (r > SAT_MAX);
        sat_lo = (r < SAT_MIN);
        if (sat_hi) begin
            stg_data_d = OUT_MAX;
        end else if (sat_lo) begin
            stg_data_d = OUT_MIN;
        end else begin
            stg_data_d = r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            stg_vld_q <= stage_en;
            if (stage_en) begin
                stg_data_q <= stg_data_d;
            end
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (stg_vld_q),
        .push_data_i (stg_data_q),
        .rdy_i       (out_rdy),
        .vld_o       (out_vld),
        .data_o      (q_out),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop)
    );

`ifdef FIR_OUT_QUANT_STATS_EN
    logic        stg_sat_q;
    logic [15:0] sat_cnt_q;

    // Only saturated samples that actually land in the FIFO are counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_sat_q <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (stage_en) begin
                stg_sat_q <= sat_hi | sat_lo;
            end
            if (stg_vld_q && stg_sat_q && !fifo_drop && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_q <= sat_cnt_q + 16'd1;
            end
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = 16'd0;
`endif

    assign ovf           = ovf_q;
    assign dbg.state     = state_q;
    assign dbg.fifo_full = fifo_full;

endmodule

// File: tb/tb_fir_out_quant.sv
// Bench for fir_out_quant: directed scenarios and randomized traffic checked against a
// queue-based reference of the output stage.
module tb_fir_out_quant;
    import fir_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WARMUP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [63:0] y_in;
    logic [5:0]  shift;
    logic        out_rdy;
    logic        out_vld;
    logic [31:0] q_out;
    logic        ovf;
    logic [15:0] sat_cnt;
    quant_dbg_t  dbg;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          warm;
    bit          stg_v;
    logic [31:0] stg_d;
    bit          stg_sat;
    bit          m_ovf;
    int          m_sat;
    bit          m_vld;

    fir_out_quant #(
        .IN_W       (64),
        .OUT_W      (32),
        .FIFO_DEPTH (DEPTH),
        .WARMUP     (WARMUP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .y_in    (y_in),
        .shift   (shift),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .q_out   (q_out),
        .ovf     (ovf),
        .sat_cnt (sat_cnt),
        .dbg     (dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-half-up of y / 2^sh, then clamp to the signed 32-bit range.
    function automatic logic [31:0] quant(input logic signed [63:0] y, input int sh_in, output bit sat);
        logic signed [127:0] v;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        int sh;
        sh = (sh_in > 63) ? 63 : sh_in;
        v  = y;
        if (sh > 0) v = v + (128'sd1 <<< (sh - 1));
        v  = v >>> sh;
        hi = (128'sd1 <<< 31) - 128'sd1;
        lo = -(128'sd1 <<< 31);
        sat = (v > hi) || (v < lo);
        if (v > hi) return 32'h7FFF_FFFF;
        if (v < lo) return 32'h8000_0000;
        return v[31:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        warm    = 0;
        stg_v   = 0;
        stg_d   = '0;
        stg_sat = 0;
        m_ovf   = 0;
        m_sat   = 0;
        m_vld   = 0;
    endtask

    task automatic check_outputs();
        logic [15:0] exp_sat;
        chk("out_vld", out_vld, m_vld);
        if (m_vld) chk("q_out", q_out, exp_q[0]);
        chk("ovf", ovf, m_ovf);
`ifdef FIR_OUT_QUANT_STATS_EN
        exp_sat = 16'(m_sat);
`else
        exp_sat = 16'd0;
`endif
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("state", dbg.state, (warm >= WARMUP) ? Q_RUN : Q_WARM);
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
    task automatic step(input bit v, input logic [63:0] y, input int sh, input bit rdy);
        bit pop;
        bit pushed;
        bit s;
        in_vld  = v;
        y_in    = y;
        shift   = 6'(sh);
        out_rdy = rdy;
        @(posedge clk);
        pop = m_vld && rdy;
        if (pop) void'(exp_q.pop_front());
        pushed = 0;
        if (stg_v) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(stg_d);
                pushed = 1;
                if (stg_sat && m_sat < 65535) m_sat++;
            end else begin
                m_ovf = 1;
            end
        end
        stg_v = 0;
        if (v) begin
            if (warm < WARMUP) begin
                warm++;
            end else begin
                stg_v   = 1;
                stg_d   = quant(y, sh, s);
                stg_sat = s;
            end
        end
        m_vld = (exp_q.size() > (pushed ? 1 : 0));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 64'd0, 0, rdy);
    endtask

    task automatic do_reset();
        in_vld  = 0;
        out_rdy = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_q_out", q_out, 32'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_sat_cnt", sat_cnt, 16'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] rand_y();
        logic [63:0] raw;
        raw = {$urandom, $urandom};
        return 64'($signed(raw) >>> $urandom_range(0, 63));
    endfunction

    initial begin
        logic [31:0] t2_exp [4];
        t2_exp = '{32'd2, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

        rst = 1'b0; in_vld = 0; y_in = '0; shift = '0; out_rdy = 0;
        model_reset();
        #1;
        chk("init_out_vld", out_vld, 1'b0);
        chk("init_q_out", q_out, 32'd0);
        chk("init_ovf", ovf, 1'b0);
        chk("init_sat_cnt", sat_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Warm-up drop and two-cycle latency
        step(1, 64'd100, 0, 1);
        step(1, 64'd200, 0, 1);
        chk("t1_still_warm", dbg.state, Q_WARM);
        step(1, 64'd300, 0, 1);
        step(1, 64'd400, 0, 0);
        chk("t1_lat_n", out_vld, 1'b0);
        idle(1, 0);
        chk("t1_lat_n1", out_vld, 1'b0);
        idle(1, 0);
        chk("t1_lat_n2", out_vld, 1'b1);
        chk("t1_q", q_out, 32'd400);
        idle(2, 1);

        // Round-half-up with shift=4
        step(1, 64'd24, 4, 0);
        step(1, 64'd23, 4, 0);
        step(1, -64'sd24, 4, 0);
        step(1, -64'sd25, 4, 0);
        idle(2, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_round", q_out, t2_exp[i]);
            step(0, 64'd0, 0, 1);
        end

        // Saturation both directions
        step(1, 64'h0000_0001_0000_0000, 0, 0);
        step(1, 64'hFFFF_FF00_0000_0000, 0, 0);
        idle(2, 0);
        chk("t3_pos_sat", q_out, 32'h7FFF_FFFF);
        step(0, 64'd0, 0, 1);
        chk("t3_neg_sat", q_out, 32'h8000_0000);
        step(0, 64'd0, 0, 1);
`ifdef FIR_OUT_QUANT_STATS_EN
        chk("t3_sat_cnt", sat_cnt, 16'd2);
`endif

        // Overflow: five pushes into four entries with the consumer stalled
        for (int i = 0; i < 5; i++) step(1, rand_y(), $urandom_range(0, 40), 0);
        idle(2, 0);
        chk("t4_ovf_set", ovf, 1'b1);
        idle(4, 1);
        chk("t4_ovf_sticky", ovf, 1'b1);
        chk("t4_drained", out_vld, 1'b0);

        // Full FIFO with simultaneous write and pop
        do_reset();
        for (int i = 0; i < WARMUP; i++) step(1, rand_y(), 0, 0);
        for (int i = 0; i < 4; i++) step(1, rand_y(), $urandom_range(0, 40), 0);
        chk("t5_full", dbg.fifo_full, 1'b0);
        step(1, rand_y(), $urandom_range(0, 40), 0);
        chk("t5_full_now", dbg.fifo_full, 1'b1);
        idle(1, 1);
        chk("t5_no_ovf", ovf, 1'b0);
        chk("t5_still_full", dbg.fifo_full, 1'b1);
        idle(6, 1);

        // Reset mid-stream with data queued, then warm-up again
        for (int i = 0; i < 3; i++) step(1, rand_y(), $urandom_range(0, 63), 0);
        do_reset();
        for (int i = 0; i < WARMUP; i++) step(1, rand_y(), 0, 1);
        idle(3, 1);
        chk("t6_no_output", out_vld, 1'b0);
        step(1, 64'd77, 0, 1);
        idle(2, 0);
        chk("t6_first_after", q_out, 32'd77);
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), rand_y(), $urandom_range(0, 63),
                 ($urandom_range(0, 3) != 0));
        end
        idle(8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
